// File: rtl/ucode_pkg.sv
// Shared microword layout, sizes, loader FSM states and the built-in multiplier program.
package ucode_pkg;

    localparam int NIB_W  = 4;
    localparam int WORD_W = 3 * NIB_W;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 6;

    // Microword fields
    localparam int CS_HI   = 11;
    localparam int CS_LO   = 10;
    localparam int BR_HI   = 9;
    localparam int BR_LO   = 7;
    localparam int CTRL_HI = 6;
    localparam int CTRL_LO = 0;

    localparam logic [1:0] CS_INC  = 2'b00;
    localparam logic [1:0] CS_BRZ  = 2'b01;
    localparam logic [1:0] CS_JUMP = 2'b10;

    typedef struct packed {
        logic [1:0] cs;
        logic [2:0] br;
        logic [6:0] ctrl;
    } uinstr_t;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} ld_state_t;

    localparam logic [WORD_W-1:0] PROG_0 = 12'h006;
    localparam logic [WORD_W-1:0] PROG_1 = 12'h040;
    localparam logic [WORD_W-1:0] PROG_2 = 12'h038;
    localparam logic [WORD_W-1:0] PROG_3 = 12'h500;
    localparam logic [WORD_W-1:0] PROG_4 = 12'h001;
    localparam logic [WORD_W-1:0] PROG_5 = 12'hA80;

    function automatic logic [WORD_W-1:0] default_word(input int idx);
        case (idx)
            0:       return PROG_0;
            1:       return PROG_1;
            2:       return PROG_2;
            3:       return PROG_3;
            4:       return PROG_4;
            5:       return PROG_5;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/ucode_mem.sv
// Microprogram store: synchronous write, registered read-before-write port, reset init.
// UCODE_LOADER_DEFAULT_EN: reset loads the multiplier program instead of all-zero no-ops.
module ucode_mem #(
    parameter int DEPTH  = ucode_pkg::DEPTH,
    parameter int ADDR_W = ucode_pkg::ADDR_W,
    parameter int WORD_W = ucode_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data
);
    import ucode_pkg::*;

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef UCODE_LOADER_DEFAULT_EN
                r_mem[i] <= default_word(i);
`else
                r_mem[i] <= '0;
`endif
            end
            r_rd_data <= '0;
        end else begin
            if (wr_en)
                r_mem[wr_addr] <= wr_data;
            // Read samples the pre-write contents: a same-cycle write shows up one cycle later.
            r_rd_data <= (int'(rd_addr) < DEPTH) ? r_mem[rd_addr] : '0;
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/ucode_loader.sv
// Nibble-at-a-time microprogram loader: strobe edge detect, word assembly, load FSM.
// UCODE_LOADER_DEFAULT_EN (see ucode_mem) selects the reset contents of the store.
module ucode_loader #(
    parameter int DEPTH  = ucode_pkg::DEPTH,
    parameter int ADDR_W = ucode_pkg::ADDR_W,
    parameter int WORD_W = ucode_pkg::WORD_W,
    parameter int NIB_W  = ucode_pkg::NIB_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [NIB_W-1:0]  nib_in,
    input  logic              nib_strobe,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        nib_cnt,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import ucode_pkg::*;

    ld_state_t         r_state;
    logic              r_strobe_q;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [1:0]        r_nib_cnt;
    logic [NIB_W-1:0]  r_n0, r_n1;
    logic              r_busy, r_done, r_err;
    logic              w_edge, w_wr_en;
    logic [WORD_W-1:0] w_wr_data;

    // Reset to 1 so a button held through reset is not taken as a press.
    always_ff @(posedge clk) begin
        if (reset) r_strobe_q <= 1'b1;
        else       r_strobe_q <= nib_strobe;
    end

    assign w_edge    = nib_strobe & ~r_strobe_q;
    assign w_wr_en   = (r_state == LOAD) && w_edge && (r_nib_cnt == 2'd2);
    assign w_wr_data = {r_n0, r_n1, nib_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wr_addr <= '0;
            r_nib_cnt <= '0;
            r_n0      <= '0;
            r_n1      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (load_en) begin
                    r_state   <= LOAD;
                    r_busy    <= 1'b1;
                    r_wr_addr <= '0;
                    r_nib_cnt <= '0;
                    r_err     <= 1'b0;
                end
                LOAD: if (w_wr_en) begin
                    // Completing edge wins over a same-cycle load_en drop.
                    r_nib_cnt <= '0;
                    if (r_wr_addr == ADDR_W'(DEPTH - 1)) begin
                        r_wr_addr <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= load_en ? DONE : IDLE;
                        r_done    <= load_en;
                    end else begin
                        r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        if (!load_en) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end else if (!load_en) begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_nib_cnt <= '0;
                    if (r_nib_cnt != 2'd0)
                        r_err <= 1'b1;
                end else if (w_edge) begin
                    if (r_nib_cnt == 2'd0) r_n0 <= nib_in;
                    else                   r_n1 <= nib_in;
                    r_nib_cnt <= r_nib_cnt + 2'd1;
                end
                DONE: if (!load_en) begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    ucode_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr_en),
        .wr_addr (r_wr_addr),
        .wr_data (w_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign wr_addr = r_wr_addr;
    assign nib_cnt = r_nib_cnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
